// File: rtl/quadrature_pkg.sv
// Shared types and constants for the quadrature generator: phase encoding,
// AB lookup, FSM states and direction codes.
package quadrature_pkg;

    typedef logic [1:0] phase_t;

    // AB pattern for each phase: p=0 -> 00, 1 -> 10, 2 -> 11, 3 -> 01 (bit 1 = A, bit 0 = B).
    localparam logic [3:0][1:0] QUAD_AB_LUT = {2'b01, 2'b11, 2'b10, 2'b00};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } quad_state_t;

    localparam logic QUAD_DIR_FWD = 1'b0;
    localparam logic QUAD_DIR_REV = 1'b1;

    // One quadrature step; forward advances the phase so a decoder counts up.
    function automatic phase_t quad_step(input phase_t p, input logic dir);
        return (dir == QUAD_DIR_REV) ? p - 2'd1 : p + 2'd1;
    endfunction

endpackage

// File: rtl/quadrature_generator_if.sv
// Command / status bundle of the quadrature generator.
interface quadrature_generator_if #(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned DIV_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic [DIV_W-1:0]  cmd_period;
    logic              abort;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_steps, cmd_period, abort,
        input  cmd_ready, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_period, abort,
        output cmd_ready, busy, done
    );
endinterface

// File: rtl/quadrature_rate_timer.sv
// Edge-rate down-counter. The accept cycle counts as the first cycle of the
// first period, so a load with period 1 ticks immediately and longer periods
// start one count short.
module quadrature_rate_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DIV_W-1:0] period_i,
    input  logic             en_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] period_clamped;

    assign period_clamped = (period_i == '0) ? DIV_W'(1) : period_i;
    assign tick_o = load_i ? (period_clamped == DIV_W'(1))
                           : (en_i && (count_q == DIV_W'(1)));

    // Latch the period on load, then count down and reload on each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q <= DIV_W'(1);
            count_q  <= DIV_W'(1);
        end else if (load_i) begin
            period_q <= period_clamped;
            count_q  <= (period_clamped == DIV_W'(1)) ? DIV_W'(1) : period_clamped - DIV_W'(1);
        end else if (en_i) begin
            count_q <= tick_o ? period_q : count_q - DIV_W'(1);
        end
    end
endmodule

// File: rtl/quadrature_generator.sv
// Quadrature A/B generator driven by a signed step command.
// Optional: define QUADGEN_POSITION_EN to add a 32-bit signed edge position output.
module quadrature_generator
    import quadrature_pkg::*;
#(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned DIV_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    quadrature_generator_if.slave bus,
    output logic                  quadA,
    output logic                  quadB
`ifdef QUADGEN_POSITION_EN
    ,
    output logic [31:0]           position
`endif
);
    quad_state_t       state_q;
    logic [STEP_W-1:0] rem_q;
    logic              dir_q;
    phase_t            p_q;
    logic [1:0]        ab_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;

    logic              accept;
    logic              tick;
    logic              timer_en;
    logic              step_en;
    logic              step_dir;
    logic              cmd_dir;
    logic [STEP_W-1:0] steps_abs;
    phase_t            p_next;

    assign accept    = bus.cmd_valid && ready_q;
    assign cmd_dir   = bus.cmd_steps[STEP_W-1] ? QUAD_DIR_REV : QUAD_DIR_FWD;
    // Two's-complement magnitude; the most-negative value maps to 2^(STEP_W-1).
    assign steps_abs = bus.cmd_steps[STEP_W-1] ? (~bus.cmd_steps + STEP_W'(1)) : bus.cmd_steps;
    assign timer_en  = (state_q == StRun) && !bus.abort;
    assign step_dir  = (state_q == StIdle) ? cmd_dir : dir_q;
    assign step_en   = (state_q == StIdle) ? (accept && tick && (steps_abs != '0))
                                           : ((state_q == StRun) && tick);
    assign p_next    = quad_step(p_q, step_dir);

    quadrature_rate_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept),
        .period_i (bus.cmd_period),
        .en_i     (timer_en),
        .tick_o   (tick)
    );

    // Command FSM with the phase register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            dir_q   <= QUAD_DIR_FWD;
            p_q     <= '0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (step_en) begin
                p_q  <= p_next;
                ab_q <= QUAD_AB_LUT[p_next];
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        dir_q <= cmd_dir;
                        if (steps_abs == '0) begin
                            state_q <= StFinish;
                            ready_q <= 1'b0;
                            done_q  <= 1'b0 | 1'b1;
                        end else if (tick && (steps_abs == STEP_W'(1))) begin
                            // Single edge at period 1 completes in the accept cycle.
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                            rem_q   <= tick ? steps_abs - STEP_W'(1) : steps_abs;
                        end
                    end
                end
                StRun: begin
                    if (bus.abort) begin
                        state_q <= StFinish;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tick) begin
                        rem_q <= rem_q - STEP_W'(1);
                        if (rem_q == STEP_W'(1)) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign quadA         = ab_q[1];
    assign quadB         = ab_q[0];
    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef QUADGEN_POSITION_EN
    logic [31:0] position_q;

    // Signed edge total, tracking exactly what a raw edge-counting decoder sees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            position_q <= '0;
        end else if (step_en) begin
            position_q <= (step_dir == QUAD_DIR_REV) ? position_q - 32'd1 : position_q + 32'd1;
        end
    end

    assign position = position_q;
`endif
endmodule

// File: tb/tb_quadrature_generator.sv
// Directed self-checking bench for quadrature_generator.
// Cycle k counts from the accept cycle T (k=1 is the first cycle after acceptance).
module tb_quadrature_generator;
    localparam int STEP_W = 16;
    localparam int DIV_W  = 16;

    logic clk = 1'b0;
    logic reset;
    logic quadA;
    logic quadB;
`ifdef QUADGEN_POSITION_EN
    logic [31:0] position;
    logic [31:0] pos0;
`endif

    quadrature_generator_if #(.STEP_W(STEP_W), .DIV_W(DIV_W)) bus ();

    quadrature_generator #(
        .STEP_W (STEP_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .quadA    (quadA),
        .quadB    (quadB)
`ifdef QUADGEN_POSITION_EN
        ,
        .position (position)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference x1 decoder fed by the generated waveform.
    logic [1:0] dec_prev = 2'b00;
    int         dec_raw  = 0;

    function automatic logic [1:0] ab2p(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [1:0] d;
        d = ab2p({quadA, quadB}) - ab2p(dec_prev);
        if (d == 2'd1) dec_raw++;
        else if (d == 2'd3) dec_raw--;
        dec_prev = {quadA, quadB};
    end

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int k, input logic [1:0] ab,
                              input logic d, input logic b, input logic r);
        check({tag, ".ab"}, k, 32'({quadA, quadB}), 32'(ab));
        check({tag, ".done"}, k, 32'(bus.done), 32'(d));
        check({tag, ".busy"}, k, 32'(bus.busy), 32'(b));
        check({tag, ".ready"}, k, 32'(bus.cmd_ready), 32'(r));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int steps, input int period);
        bus.cmd_valid  = 1'b1;
        bus.cmd_steps  = 16'(steps);
        bus.cmd_period = 16'(period);
        cyc();
        bus.cmd_valid  = 1'b0;
        bus.cmd_steps  = 16'h7abc;
        bus.cmd_period = 16'h0005;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] fwd [4];
        logic [1:0] b2b [8];
        logic [1:0] ab_e;
        int         raw0;
        int         k;

        fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
        b2b = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

        reset          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_steps  = '0;
        bus.cmd_period = '0;
        bus.abort      = 1'b0;
        #12;
        expect_out("reset", 0, 2'b00, 1'b0, 1'b0, 1'b1);
`ifdef QUADGEN_POSITION_EN
        check("reset.pos", 0, position, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // +8 at period 4: edges every 4 cycles, done with the eighth.
        issue(8, 4);
        ab_e = 2'b00;
        for (int i = 1; i <= 32; i++) begin
            if (i > 1) cyc();
            if (i % 4 == 0) ab_e = fwd[(i / 4 - 1) % 4];
            expect_out("fwd8", i, ab_e, i == 32, i != 32, i == 32);
        end
`ifdef QUADGEN_POSITION_EN
        check("fwd8.pos", 32, position, 32'd8);
`endif
        cyc();
        expect_out("fwd8.after", 33, 2'b00, 1'b0, 1'b0, 1'b1);

        // Abort while idle does nothing.
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        expect_out("idle_abort", 0, 2'b00, 1'b0, 1'b0, 1'b1);

        // Zero-step command: FINISH then IDLE, no edge.
        issue(0, 5);
        expect_out("zero", 1, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_out("zero", 2, 2'b00, 1'b0, 1'b0, 1'b1);

        // -3 at period 1 from p=0.
        issue(-3, 1);
        expect_out("rev3", 1, 2'b01, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("rev3", 2, 2'b11, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("rev3", 3, 2'b10, 1'b1, 1'b0, 1'b1);
        cyc();

        // +3 at period 1 returns to p=0.
        issue(3, 1);
        expect_out("fwd3", 1, 2'b11, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("fwd3", 2, 2'b01, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("fwd3", 3, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc();

        // +100 at period 2 with abort in cycle T+11: 5 edges, frozen at 10.
        issue(100, 2);
        ab_e = 2'b00;
        for (int i = 1; i <= 11; i++) begin
            if (i > 1) cyc();
            if (i % 2 == 0) ab_e = fwd[(i / 2 - 1) % 4];
            expect_out("abort", i, ab_e, 1'b0, 1'b1, 1'b0);
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        expect_out("abort", 12, 2'b10, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_out("abort", 13, 2'b10, 1'b0, 1'b0, 1'b1);

        // -1 with period 0 (clamped to 1): one edge, done right away.
        issue(-1, 0);
        expect_out("rev1p0", 1, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc();

        // Back-to-back +4 then -4 at period 3 with valid held high.
        bus.cmd_valid  = 1'b1;
        bus.cmd_steps  = 16'(4);
        bus.cmd_period = 16'(3);
        cyc();
        bus.cmd_steps  = 16'(-4);
        ab_e = 2'b00;
        for (int i = 1; i <= 24; i++) begin
            if (i > 1) cyc();
            if (i == 13) bus.cmd_valid = 1'b0;
            if (i % 3 == 0) ab_e = b2b[i / 3 - 1];
            expect_out("b2b", i, ab_e, (i == 12) || (i == 24), (i != 12) && (i != 24),
                       (i == 12) || (i == 24));
        end
        cyc();

        // Loopback: +400 at period 8, decoder should advance by 100.
        raw0 = dec_raw;
`ifdef QUADGEN_POSITION_EN
        pos0 = position;
`endif
        issue(400, 8);
        k = 1;
        while (bus.done !== 1'b1 && k < 4000) begin
            cyc();
            k++;
        end
        check("loop.done_cycle", k, 32'(k), 32'd3200);
        cyc();
        check("loop.decoder", k, 32'((dec_raw - raw0) / 4), 32'd100);
`ifdef QUADGEN_POSITION_EN
        check("loop.pos", k, position - pos0, 32'd400);
`endif

        // Reset in the middle of a command drops everything asynchronously.
        issue(4, 3);
        cyc();
        cyc();
        expect_out("midreset", 3, 2'b10, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        expect_out("midreset", 4, 2'b00, 1'b0, 1'b0, 1'b1);
`ifdef QUADGEN_POSITION_EN
        check("midreset.pos", 4, position, 32'd0);
`endif
        reset = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/quadrature_generator.md
# quadrature_generator

Synthesises a clean quadrature (A/B) waveform from a signed step command, emitting a programmed number of edges at a programmed rate. It is the stimulus/emulation counterpart of the clocked quadrature decoder. It drives encoder inputs for loopback tests on the DE0-Nano and replaces a physical rotary encoder during bring-up. Commands arrive through a valid/ready handshake; a one-cycle `done` marks completion.

## Interface
- `STEP_W`, 16: width of signed edge-count command.
- `DIV_W`, 16: width of edge-period command.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: generator idle and able to accept a command.
- `cmd_steps` in STEP_W: signed edge count; >0 forward, <0 reverse.
- `cmd_period` in DIV_W: clocks between successive edges; 0 treated as 1.
- `abort` in 1: terminate the running command.
- `quadA`, `quadB` out 1: registered quadrature outputs.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- Phase index p (2 bits) maps to AB as: p=0→00, 1→10, 2→11, 3→01.
- Forward adds 1 to p mod 4 per edge; reverse subtracts 1.
- With this mapping, forward makes the decoder count up.
- Exactly one of A/B changes per edge.
- FSM states:
  - IDLE (`cmd_ready`=1).
  - RUN (`busy`=1).
  - FINISH (one cycle, `done`=1; used only for zero-step or abort).
- Accept when `cmd_valid`&&`cmd_ready`. At acceptance the block latches:
  - remaining = |cmd_steps| as an unsigned STEP_W value, so the most-negative value gives 2^(STEP_W-1) edges;
  - dir = sign of `cmd_steps`;
  - timer = max(`cmd_period`,1).
- `cmd_steps`=0: IDLE→FINISH→IDLE; no edge emitted.
- RUN: timer decrements each cycle. When timer==1:
  - step p;
  - decrement remaining;
  - reload timer.
- On the last edge, go straight to IDLE with `done`=1 in that same cycle.
- `abort` in RUN: no further edges; go to FINISH, then IDLE. p holds, so the outputs stay at the current phase.
- `abort` in IDLE has no effect.
- `cmd_valid` ignored while busy. Command inputs need only be stable in the accept cycle.
- Phase is never reset between commands; position is continuous across commands.

## Timing
- Reset values:
  - `quadA`=0, `quadB`=0, p=0;
  - `busy`=0, `done`=0, `cmd_ready`=1;
  - FSM in IDLE.
- Accept at edge T:
  - `busy`=1 and `cmd_ready`=0 from T+1;
  - first output edge visible at T+P, where P = max(`cmd_period`,1);
  - subsequent edges every P cycles.
- Nth (last) edge visible at T+N·P. In that cycle `done`=1, `busy`=0 and `cmd_ready`=1.
- A new command can be accepted in that cycle, giving gapless back-to-back streams.
- Zero-step: `done` at T+1, `cmd_ready`=1 at T+2.
- Abort sampled at edge S: no edge at S even if the timer expired; `done` at S+1, idle at S+2.
- Reset mid-command returns immediately to reset values; AB drops to 00 asynchronously.
- All outputs are registered.

## Configuration
- `QUADGEN_POSITION_EN`:
  - When defined, adds output `position` [31:0], reset 0.
  - It increments on each forward edge and decrements on each reverse edge, two's-complement wrap, same cycle as the edge.
  - Its value equals the decoder's raw edge total for loopback checking.
- Without the macro, the port and counter are absent and all other behaviour is identical.

## Structure
- Package `quadrature_pkg`:
  - phase typedef (2-bit);
  - AB lookup constant for p=0..3;
  - FSM state typedef (IDLE, RUN, FINISH);
  - `QUAD_DIR_FWD`/`QUAD_DIR_REV` constants.
- One sub-module, `quadrature_rate_timer`: a DIV_W down-counter with load, zero-clamp to 1, and a one-cycle `tick`.
- FSM, step counter and phase register stay in the top module.

## Test plan
- Reset, then `cmd_steps`=+8, `cmd_period`=4:
  - AB sequence 10,11,01,00,10,11,01,00;
  - edges 4 cycles apart, first at T+4;
  - `done` at T+32.
- `cmd_steps`=−3, `cmd_period`=1, starting from p=0: AB 01,11,10 on three consecutive cycles; `done` with third edge.
- `cmd_steps`=0: no AB change; `done` at T+1; `cmd_ready` at T+2.
- `cmd_steps`=+100, period 2, `abort` at T+11:
  - exactly 5 edges;
  - AB frozen at 10;
  - `done` at T+12.
- Back-to-back +4 then −4, period 3, second `cmd_valid` held high: second accept coincides with first `done`; AB returns to 00; uniform 3-cycle spacing.
- Loopback into the clocked quadrature decoder with +400 edges, period 8: decoder count = 100; with `QUADGEN_POSITION_EN`, `position` = 400.
